// File: rtl/hazard_ctrl_unit_if.sv
// Interface bundling the pipeline-side signals of the hazard control unit.
//   slave  : the hazard control unit (consumes decode/memory status, drives controls)
//   master : the pipeline around it (drives decode/memory status, consumes controls)
// Signals:
//   inst_i, idex_memread_i, idex_rt_i, branch_taken_i, jump_i, mem_req_i, mem_ready_i  (to unit)
//   HD_o, pc_write_o, bubble_o, flush_o, mem_stall_o, timeout_o, stall_cnt_o, flush_cnt_o (from unit)
interface hazard_ctrl_unit_if #(
    parameter int unsigned STAT_W = 16
);
    logic [31:0]       inst_i;
    logic              idex_memread_i;
    logic [4:0]        idex_rt_i;
    logic              branch_taken_i;
    logic              jump_i;
    logic              mem_req_i;
    logic              mem_ready_i;
    logic              HD_o;
    logic              pc_write_o;
    logic              bubble_o;
    logic              flush_o;
    logic              mem_stall_o;
    logic              timeout_o;
    logic [STAT_W-1:0] stall_cnt_o;
    logic [STAT_W-1:0] flush_cnt_o;

    modport slave (
        input  inst_i, idex_memread_i, idex_rt_i, branch_taken_i, jump_i, mem_req_i, mem_ready_i,
        output HD_o, pc_write_o, bubble_o, flush_o, mem_stall_o, timeout_o, stall_cnt_o,
               flush_cnt_o
    );

    modport master (
        output inst_i, idex_memread_i, idex_rt_i, branch_taken_i, jump_i, mem_req_i, mem_ready_i,
        input  HD_o, pc_write_o, bubble_o, flush_o, mem_stall_o, timeout_o, stall_cnt_o,
               flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard control unit: produces IF/ID stall (HD) and flush controls, inserts ID/EX bubbles on
// load-use hazards, freezes the pipe during multi-cycle data-memory accesses, and latches a
// sticky timeout (ERR) if a memory access never completes. Keeps saturating stall/flush stats.
// Ports:
//   clk_i  : clock, all state updates on posedge
//   rst_i  : synchronous reset, active low
//   bus    : hazard_ctrl_unit_if.slave (decode/memory status in, pipeline controls out)
module hazard_ctrl_unit #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned STAT_W      = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    hazard_ctrl_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StErr     = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0]  TimeoutVal = CNT_W'(MEM_TIMEOUT);
    localparam logic [STAT_W-1:0] StatMax    = '1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lu, memwait, redirect;
    logic hd, bubble, flush, mem_stall;

    // Only the rs/rt fields take part in hazard detection.
    logic unused_inst;
    assign unused_inst = ^{bus.inst_i[31:26], bus.inst_i[15:0]};

    assign lu = bus.idex_memread_i && (bus.idex_rt_i != 5'd0) &&
                ((bus.idex_rt_i == bus.inst_i[25:21]) || (bus.idex_rt_i == bus.inst_i[20:16]));
    assign memwait  = bus.mem_req_i && !bus.mem_ready_i;
    assign redirect = bus.branch_taken_i || bus.jump_i;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        hd         = 1'b0;
        bubble     = 1'b0;
        flush      = 1'b0;
        mem_stall  = 1'b0;

        case (state_q)
            StMemWait: begin
                if (!bus.mem_ready_i) begin
                    mem_stall = 1'b1;
                    if (wait_cnt_q == TimeoutVal) begin
                        state_d   = StErr;
                        timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    // Access completes: the pipe moves this cycle, so hazards apply as in RUN.
                    state_d    = StRun;
                    wait_cnt_d = '0;
                    if (lu) begin
                        hd     = 1'b1;
                        bubble = 1'b1;
                    end else if (redirect) begin
                        flush = 1'b1;
                    end
                end
            end
            StErr: begin
                hd        = 1'b1;
                mem_stall = 1'b1;
            end
            default: begin
                // StRun and the unused encoding both behave as RUN.
                state_d = StRun;
                if (memwait) begin
                    mem_stall  = 1'b1;
                    state_d    = StMemWait;
                    wait_cnt_d = CNT_W'(1);
                end else if (lu) begin
                    // A taken branch in the same cycle is re-resolved after the re-decode.
                    hd     = 1'b1;
                    bubble = 1'b1;
                end else if (redirect) begin
                    flush = 1'b1;
                end
            end
        endcase

        if (!rst_i) begin
            state_d    = StRun;
            wait_cnt_d = '0;
            timeout_d  = 1'b0;
            hd         = 1'b0;
            bubble     = 1'b0;
            flush      = 1'b0;
            mem_stall  = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((hd || mem_stall) && (stall_cnt_q != StatMax)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush && (flush_cnt_q != StatMax)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
        if (!rst_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        state_q     <= state_d;
        wait_cnt_q  <= wait_cnt_d;
        timeout_q   <= timeout_d;
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign bus.HD_o        = hd;
    assign bus.bubble_o    = bubble;
    assign bus.flush_o     = flush;
    assign bus.mem_stall_o = mem_stall;
    assign bus.pc_write_o  = !(hd || mem_stall);
    assign bus.timeout_o   = timeout_q && rst_i;
    assign bus.stall_cnt_o = rst_i ? stall_cnt_q : '0;
    assign bus.flush_cnt_o = rst_i ? flush_cnt_q : '0;

endmodule
